// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the ServoController pulse stages.
package servo_pkg;

  localparam int POS_W            = 8;
  localparam int DEF_PERIOD_TICKS = 2000;
  localparam int DEF_MIN_TICKS    = 100;
  localparam int DEF_POS_MAX      = 100;
  localparam int DEF_POS_RESET    = 50;

  typedef enum logic [1:0] {
    IDLE,
    RUN_HIGH,
    RUN_LOW
  } servo_state_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] lim);
    return (pos > lim) ? lim : pos;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Registers a clk-synchronous timebase and emits a one-clk pulse on each rising edge.
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo frame generator driven by the divider tick; commands apply only at frame starts.
// Optional per-frame slew limiting is built when SERVO_SLEW_EN is defined.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int STEP_TICKS   = 1,
  parameter int POS_MAX      = DEF_POS_MAX,
  parameter int POS_RESET    = DEF_POS_RESET,
  parameter int SLEW_STEP    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_pos,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [POS_W-1:0] pos_active
);

  localparam int CW = $clog2(PERIOD_TICKS);
  localparam int WW = CW + 1;
  localparam logic [CW-1:0]    LAST_TICK   = CW'(PERIOD_TICKS - 1);
  localparam logic [POS_W-1:0] POS_MAX_L   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_RESET_L = POS_W'(POS_RESET);

  // The longest pulse must leave at least one low tick in the frame.
  if (MIN_TICKS + POS_MAX * STEP_TICKS >= PERIOD_TICKS) begin : g_bad_timing
    $error("servo_pwm_gen: MIN_TICKS + POS_MAX*STEP_TICKS must be below PERIOD_TICKS");
  end
  if (POS_RESET > POS_MAX || POS_MAX >= (1 << POS_W) || SLEW_STEP < 1) begin : g_bad_pos
    $error("servo_pwm_gen: illegal POS_RESET, POS_MAX or SLEW_STEP");
  end

  servo_state_t     state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pwm_d, fs_d, frame_go, tick, accept;
  logic             pending_q;
  logic [POS_W-1:0] pending_pos_q, target_q, next_target, next_active;
  logic [WW-1:0]    width, count_inc;

  tick_edge_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .sig   (div_clk),
    .rise  (tick)
  );

  assign width     = WW'(MIN_TICKS) + WW'(pos_active) * WW'(STEP_TICKS);
  assign count_inc = WW'(count_q) + WW'(1);
  assign cmd_ready = ~pending_q;
  assign accept    = cmd_valid & cmd_ready;

  assign next_target = pending_q ? pending_pos_q : target_q;

`ifdef SERVO_SLEW_EN
  localparam logic [POS_W-1:0] SLEW_L = POS_W'(SLEW_STEP);

  always_comb begin
    next_active = next_target;
    if (next_target > pos_active) begin
      if (next_target - pos_active > SLEW_L) next_active = pos_active + SLEW_L;
    end else if (pos_active - next_target > SLEW_L) begin
      next_active = pos_active - SLEW_L;
    end
  end
`else
  assign next_active = next_target;
`endif

  // Dropping enable parks the output at once, without waiting for a tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pwm_d    = pwm_out;
    fs_d     = 1'b0;
    frame_go = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
      pwm_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d  = '0;
          pwm_d    = 1'b0;
          frame_go = tick;
        end
        RUN_HIGH: begin
          if (tick) begin
            count_d = count_q + CW'(1);
            if (count_inc == width) begin
              pwm_d   = 1'b0;
              state_d = RUN_LOW;
            end
          end
        end
        RUN_LOW: begin
          if (tick) begin
            if (count_q == LAST_TICK) frame_go = 1'b1;
            else                      count_d  = count_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (frame_go) begin
        state_d = RUN_HIGH;
        count_d = '0;
        pwm_d   = 1'b1;
        fs_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pwm_out     <= pwm_d;
      frame_start <= fs_d;
    end
  end

  // A command accepted on a frame-start clk can only land while nothing is pending,
  // so it is always deferred to the following frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_active    <= POS_RESET_L;
      target_q      <= POS_RESET_L;
      pending_q     <= 1'b0;
      pending_pos_q <= '0;
    end else begin
      if (frame_go) begin
        target_q   <= next_target;
        pos_active <= next_active;
        pending_q  <= 1'b0;
      end
      if (accept) begin
        pending_q     <= 1'b1;
        pending_pos_q <= clamp_pos(cmd_pos, POS_MAX_L);
      end
    end
  end

endmodule
